// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared types and helpers for the full-speed USB endpoint arbiters.
//   arb_state_e : arbiter FSM state encoding
//   clog2w      : register width helper, never returns less than one bit
package usb_fs_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap.
//   req_i : request vector
//   ptr_i : starting index of the search (must be < N)
//   gnt_o : one-hot winner, zero when no request is set
//   idx_o : index of the winner, zero when no request is set
module rr_pick import usb_fs_pkg::*; #(
  parameter int N  = 4,
  parameter int PW = clog2w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);
  logic [PW-1:0] j;
  // Walk offsets from farthest to nearest so the closest request to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/usb_fs_in_ep_arbiter.sv
// usb_fs_in_ep_arbiter: round-robin, packet-granular sharing of the IN endpoint fill path.
//   req_valid/req_put/req_data/req_done : per-endpoint requester side
//   req_grant/req_free                  : registered one-hot grant, grant qualified by engine space
//   in_ep_data_free                     : per-endpoint space indication from the IN protocol engine
//   in_ep_data_put/in_ep_data/in_ep_data_done : byte fill path towards the IN protocol engine
module usb_fs_in_ep_arbiter import usb_fs_pkg::*; #(
  parameter int NUM_IN_EPS         = 11,
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int HOLD_TIMEOUT       = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN_EPS-1:0]   req_valid,
  input  logic [NUM_IN_EPS-1:0]   req_put,
  input  logic [8*NUM_IN_EPS-1:0] req_data,
  input  logic [NUM_IN_EPS-1:0]   req_done,
  output logic [NUM_IN_EPS-1:0]   req_grant,
  output logic [NUM_IN_EPS-1:0]   req_free,
  input  logic [NUM_IN_EPS-1:0]   in_ep_data_free,
  output logic [NUM_IN_EPS-1:0]   in_ep_data_put,
  output logic [7:0]              in_ep_data,
  output logic [NUM_IN_EPS-1:0]   in_ep_data_done
);
  localparam int PW = clog2w(NUM_IN_EPS);
  localparam int BW = clog2w(MAX_IN_PACKET_SIZE + 1);
  localparam int IW = clog2w(HOLD_TIMEOUT + 1);
  arb_state_e state_q, state_d;
  logic [PW-1:0] grant_idx_q, grant_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [NUM_IN_EPS-1:0] pick_oh, g_oh;
  logic granted, put_g, done_g, full_g;
  rr_pick #(.N(NUM_IN_EPS), .PW(PW)) u_pick (
    .req_i (req_valid & in_ep_data_free),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx)
  );
  assign granted = state_q == ARB_GRANTED;
  assign g_oh    = granted ? {{(NUM_IN_EPS-1){1'b0}}, 1'b1} << grant_idx_q : '0;
  assign put_g   = granted & req_put[grant_idx_q] & in_ep_data_free[grant_idx_q];
  // Done covers explicit end, withdrawal (flush) and the stall timeout; a put in the
  // final stalled cycle keeps the grant alive instead.
  assign done_g  = granted & (req_done[grant_idx_q] | ~req_valid[grant_idx_q] |
                   (idle_cnt_q == IW'(HOLD_TIMEOUT - 1) & ~put_g));
  // A full packet releases silently: the engine completes it on its own.
  assign full_g  = put_g & (byte_cnt_q == BW'(MAX_IN_PACKET_SIZE - 1));
  assign req_grant       = g_oh;
  assign req_free        = g_oh & in_ep_data_free;
  assign in_ep_data_put  = put_g ? g_oh : '0;
  assign in_ep_data_done = done_g ? g_oh : '0;
  assign in_ep_data      = granted ? req_data[{grant_idx_q, 3'b000} +: 8] : 8'h00;
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    case (state_q)
      ARB_IDLE: if (|pick_oh) begin
        state_d     = ARB_GRANTED;
        grant_idx_d = pick_idx;
        byte_cnt_d  = '0;
        idle_cnt_d  = '0;
      end
      ARB_GRANTED: begin
        byte_cnt_d = put_g ? byte_cnt_q + 1'b1 : byte_cnt_q;
        idle_cnt_d = put_g ? '0 : (idle_cnt_q == IW'(HOLD_TIMEOUT)) ? idle_cnt_q : idle_cnt_q + 1'b1;
        state_d    = (done_g | full_g) ? ARB_RELEASE : ARB_GRANTED;
      end
      default: begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (grant_idx_q == PW'(NUM_IN_EPS - 1)) ? '0 : grant_idx_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end
endmodule
